// File: rtl/snake_input_queue.sv
// rtl/snake_input_queue.sv - key edge detection, game state machine and turn FIFO for the snake core
module snake_input_queue #(
  parameter int DEPTH = 4,
  parameter logic [1:0] INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key_direction_in,
  input  logic       key_direction_valid_in,
  input  logic       key_start_pause_in,
  input  logic       key_reset_in,
  input  logic       game_tick,
  output logic [1:0] heading,
  output logic       heading_update,
  output logic [1:0] game_state,
  output logic       game_reset_pulse,
  output logic [3:0] queue_count,
  output logic       overflow
);

  localparam int PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int SLOTS = 1 << PW;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [3:0] CNT_FULL = 4'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  state_t state;

  logic [1:0]    fifo [SLOTS];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [1:0] dir_prev;
  logic       valid_prev;
  logic       sp_prev;
  logic       rst_prev;

  logic          dir_evt;
  logic          sp_evt;
  logic          rst_evt;
  logic [PW-1:0] tail_ptr;
  logic [1:0]    ref_dir;
  logic          legal;
  logic          do_pop;
  logic          do_push;
  logic          do_drop;

  // Level-to-event conversion relies on last cycle's copy of every key input
  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_prev   <= 2'b00;
      valid_prev <= 1'b0;
      sp_prev    <= 1'b0;
      rst_prev   <= 1'b0;
    end else begin
      dir_prev   <= key_direction_in;
      valid_prev <= key_direction_valid_in;
      sp_prev    <= key_start_pause_in;
      rst_prev   <= key_reset_in;
    end
  end

  // Event detection and push/pop decisions, all from start-of-cycle state
  always_comb begin
    dir_evt  = key_direction_valid_in & (!valid_prev | (key_direction_in != dir_prev));
    sp_evt   = key_start_pause_in & !sp_prev;
    rst_evt  = key_reset_in & !rst_prev;
    tail_ptr = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
    ref_dir  = (queue_count != 4'd0) ? fifo[tail_ptr] : heading;
    // A turn must change direction and must not reverse onto the snake's own body
    legal    = dir_evt && (state == ST_RUN) && (key_direction_in != ref_dir)
               && (key_direction_in != {ref_dir[1], ~ref_dir[0]});
    do_pop   = game_tick && (state == ST_RUN) && (queue_count != 4'd0);
    // A pop in the same cycle frees the slot the push needs
    do_push  = legal && ((queue_count != CNT_FULL) || do_pop);
    do_drop  = legal && (queue_count == CNT_FULL) && !do_pop;
  end

  // Game state machine, turn FIFO and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= ST_IDLE;
      heading          <= INIT_DIR;
      heading_update   <= 1'b0;
      game_reset_pulse <= 1'b0;
      queue_count      <= 4'd0;
      overflow         <= 1'b0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      for (int i = 0; i < SLOTS; i++) fifo[i] <= 2'b00;
    end else begin
      heading_update   <= 1'b0;
      game_reset_pulse <= 1'b0;
      if (rst_evt) begin
        state            <= ST_IDLE;
        heading          <= INIT_DIR;
        game_reset_pulse <= 1'b1;
        queue_count      <= 4'd0;
        overflow         <= 1'b0;
        rd_ptr           <= '0;
        wr_ptr           <= '0;
      end else begin
        if (sp_evt) begin
          case (state)
            ST_IDLE:   state <= ST_RUN;
            ST_RUN:    state <= ST_PAUSED;
            ST_PAUSED: state <= ST_RUN;
            default:   state <= ST_IDLE;
          endcase
        end
        if (do_pop) begin
          heading        <= fifo[rd_ptr];
          heading_update <= 1'b1;
          rd_ptr         <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
        if (do_push) begin
          fifo[wr_ptr] <= key_direction_in;
          wr_ptr       <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        end
        if (do_push && !do_pop) begin
          queue_count <= queue_count + 4'd1;
        end else if (do_pop && !do_push) begin
          queue_count <= queue_count - 4'd1;
        end
        if (do_drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_snake_input_queue.sv
// tb/tb_snake_input_queue.sv - directed vector bench for snake_input_queue
module tb_snake_input_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key_direction_in;
  logic       key_direction_valid_in;
  logic       key_start_pause_in;
  logic       key_reset_in;
  logic       game_tick;
  logic [1:0] heading;
  logic       heading_update;
  logic [1:0] game_state;
  logic       game_reset_pulse;
  logic [3:0] queue_count;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] dir;
    logic       vld;
    logic       sp;
    logic       kr;
    logic       tk;
    logic [1:0] e_head;
    logic [3:0] e_cnt;
    logic [1:0] e_st;
    logic       e_ovf;
    logic       e_hu;
    logic       e_grp;
  } vec_t;

  vec_t vecs[$];

  snake_input_queue #(.DEPTH(4), .INIT_DIR(2'b11)) dut (
    .clk(clk),
    .reset(reset),
    .key_direction_in(key_direction_in),
    .key_direction_valid_in(key_direction_valid_in),
    .key_start_pause_in(key_start_pause_in),
    .key_reset_in(key_reset_in),
    .game_tick(game_tick),
    .heading(heading),
    .heading_update(heading_update),
    .game_state(game_state),
    .game_reset_pulse(game_reset_pulse),
    .queue_count(queue_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [1:0] eh, input logic [3:0] ec, input logic [1:0] es,
                           input logic eo, input logic ehu, input logic eg);
    check("heading", idx, {2'b00, heading}, {2'b00, eh});
    check("queue_count", idx, queue_count, ec);
    check("game_state", idx, {2'b00, game_state}, {2'b00, es});
    check("overflow", idx, {3'b000, overflow}, {3'b000, eo});
    check("heading_update", idx, {3'b000, heading_update}, {3'b000, ehu});
    check("game_reset_pulse", idx, {3'b000, game_reset_pulse}, {3'b000, eg});
  endtask

  task automatic v(input logic [1:0] dir, input logic vld, input logic sp, input logic kr, input logic tk,
                   input logic [1:0] eh, input logic [3:0] ec, input logic [1:0] es,
                   input logic eo, input logic ehu, input logic eg);
    vec_t r;
    r.dir = dir; r.vld = vld; r.sp = sp; r.kr = kr; r.tk = tk;
    r.e_head = eh; r.e_cnt = ec; r.e_st = es; r.e_ovf = eo; r.e_hu = ehu; r.e_grp = eg;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic [1:0] dir, input logic vld, input logic sp, input logic kr, input logic tk);
    key_direction_in       = dir;
    key_direction_valid_in = vld;
    key_start_pause_in     = sp;
    key_reset_in           = kr;
    game_tick              = tk;
  endtask

  initial begin
    //  dir    v     sp    kr    tk     head   cnt  st     ovf   hu    grp
    v(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0); // 1 start
    v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0); // push up
    v(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 2'b01, 1'b0, 1'b1, 1'b0); // tick
    v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0); // reversal
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0); // duplicate
    v(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0); // opposes tail
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd2, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd2, 2'b01, 1'b0, 1'b0, 1'b0); // opposes tail
    v(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd4, 2'b01, 1'b0, 1'b0, 1'b0); // full
    v(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd4, 2'b01, 1'b1, 1'b0, 1'b0); // overflow
    v(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd4, 2'b01, 1'b1, 1'b0, 1'b0);
    v(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'd3, 2'b01, 1'b1, 1'b1, 1'b0); // drain, wraps
    v(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd2, 2'b01, 1'b1, 1'b1, 1'b0);
    v(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'd1, 2'b01, 1'b1, 1'b1, 1'b0);
    v(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 2'b01, 1'b1, 1'b1, 1'b0);
    v(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0); // empty tick
    v(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 2'b01, 1'b1, 1'b0, 1'b0);
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd2, 2'b01, 1'b1, 1'b0, 1'b0);
    v(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'd1, 2'b01, 1'b1, 1'b1, 1'b0);
    v(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 2'b01, 1'b1, 1'b1, 1'b0); // push+pop
    v(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 2'b01, 1'b1, 1'b1, 1'b0); // held key
    v(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'd1, 2'b01, 1'b1, 1'b0, 1'b0);
    v(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'd2, 2'b01, 1'b1, 1'b0, 1'b0);
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'd3, 2'b01, 1'b1, 1'b0, 1'b0);
    v(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1); // game reset
    v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0); // idle dir
    v(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd2, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd4, 2'b01, 1'b0, 1'b0, 1'b0);
    v(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd4, 2'b01, 1'b0, 1'b1, 1'b0); // full push+pop
    v(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'd3, 2'b01, 1'b0, 1'b1, 1'b0);
    v(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'd3, 2'b10, 1'b0, 1'b0, 1'b0); // pause
    v(2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd3, 2'b10, 1'b0, 1'b0, 1'b0); // ignored
    v(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd3, 2'b10, 1'b0, 1'b0, 1'b0);
    v(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0); // resume

    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(0, 2'b11, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].dir, vecs[i].vld, vecs[i].sp, vecs[i].kr, vecs[i].tk);
      @(posedge clk);
      #1;
      check_all(i + 1, vecs[i].e_head, vecs[i].e_cnt, vecs[i].e_st, vecs[i].e_ovf, vecs[i].e_hu, vecs[i].e_grp);
    end

    // Release start/pause, then hold it for 50 cycles: exactly one RUN->PAUSED
    @(negedge clk);
    drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("hold_pre_state", 100, {2'b00, game_state}, 4'd1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      drive(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("hold_state", 101 + c, {2'b00, game_state}, 4'd2);
    end

    // Hardware reset mid-operation discards queued turns
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all(200, 2'b11, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_all(201, 2'b11, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snake_input_queue.md
# snake_input_queue

Sits between the PS2 keyboard decoder and the snake game core. Converts the decoder's level-style key outputs into discrete events. Runs the IDLE/RUN/PAUSED game state machine. Buffers legal direction changes in a small FIFO so that one turn is applied per game tick, with 180° reversals and duplicate turns rejected.

## Interface
- DEPTH, 4: turn FIFO depth; legal range 2..8.
- INIT_DIR, 2'b11: heading after reset or game reset (00 up, 01 down, 10 left, 11 right).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- key_direction_in  in  2  direction code from decoder (00 up, 01 down, 10 left, 11 right).
- key_direction_valid_in  in  1  level; high while a direction key is held.
- key_start_pause_in  in  1  level; high while start/pause key is held.
- key_reset_in  in  1  level; high while game-reset key is held.
- game_tick  in  1  one-cycle pulse; snake step strobe from game timer.
- heading  out  2  current applied direction.
- heading_update  out  1  one-cycle pulse when heading is loaded from the FIFO.
- game_state  out  2  00 IDLE, 01 RUN, 10 PAUSED (11 never driven).
- game_reset_pulse  out  1  one-cycle pulse on game reset.
- queue_count  out  4  entries in the FIFO, 0..DEPTH.
- overflow  out  1  sticky; set when a legal turn is dropped because the FIFO is full.

## Operation
- Input history: previous-cycle copies of all four key inputs are registered. All history registers clear to 0 on reset.
- Events, evaluated combinationally each cycle:
  - dir_evt = valid_in & (!valid_prev | dir_in != dir_prev).
  - sp_evt = start_pause_in & !start_pause_prev.
  - rst_evt = reset_in & !reset_prev.
- State machine, transitions on sp_evt:
  - IDLE→RUN.
  - RUN→PAUSED.
  - PAUSED→RUN.
  - rst_evt from any state → IDLE.
- Reference direction: the FIFO tail entry if queue_count>0, else heading.
- Push rule: a dir_evt pushes only when all of the following hold:
  - state is RUN;
  - dir_in differs from the reference direction;
  - dir_in is not the reference's opposite (opposite means bit1 equal, bit0 different).
- Rejected or out-of-state dir_evts have no effect.
- Full FIFO: a legal dir_evt is dropped and overflow is set.
- Pop: game_tick in RUN with queue_count>0 loads the head entry into heading and pulses heading_update.
- game_tick in any other case has no effect.
- Same-cycle push and pop: both occur and queue_count is unchanged.
  - The push reference is still the tail, including when the tail equals the head being popped.
  - A push into a full FIFO during a pop succeeds, with no overflow.
- rst_evt priority: it overrides every other event in the same cycle.
  - FIFO flushes (count 0); heading=INIT_DIR; overflow cleared; state IDLE; game_reset_pulse=1.
  - Same-cycle sp_evt, dir_evt and game_tick are ignored.
- All decisions use state, count and heading as held at the start of the cycle.
- FIFO storage: circular buffer with read/write pointers that wrap at DEPTH (not at a power of two).

## Timing
- Reset (reset==0 at a clk edge) clears the block:
  - heading=INIT_DIR, game_state=IDLE, queue_count=0.
  - heading_update=0, game_reset_pulse=0, overflow=0; pointers at 0.
- Reset asserted mid-operation discards all queued turns on that edge.
- Event latency: an input change in cycle N is an event in cycle N. Its effect (state, queue_count, overflow) is visible after the edge ending cycle N.
- Tick latency: heading and heading_update are registered and visible the cycle after game_tick. heading_update lasts exactly one cycle.
- game_reset_pulse is registered, one cycle, the cycle after rst_evt.
- A held key produces exactly one event; re-arming requires release or, for direction only, a code change.

## Test plan
- Reset, then sp_evt: game_state 00→01. Push dir 00 (up), then tick → heading=00 one cycle after tick, heading_update pulses once.
- From heading=11 (right), push 10 (left) → rejected, queue_count stays 0. Push 00 then 01 → only 00 queued (01 opposes tail 00), count=1.
- DEPTH=4: queue 4 alternating legal turns (00,10,01,11) with no tick → count=4. A fifth legal turn sets overflow=1 and count stays 4. Four ticks drain the turns in order and pointers wrap correctly.
- Count=1 with tail 00; in the same cycle tick and dir 10 → heading=00, count stays 1, queue holds 10.
- Rising edge of key_reset_in with count=3, state RUN, and a simultaneous tick:
  - heading=INIT_DIR, count=0, overflow=0, state IDLE;
  - game_reset_pulse for 1 cycle;
  - no heading_update.
- PAUSED state: direction keys and ticks are ignored (count and heading unchanged). A second sp_evt returns to RUN. Holding start/pause for 50 cycles produces a single transition.
